etapa_busqueda: RTL and testbench



---
 rtl/etapa_busqueda.sv | 101 ++++++++++
 tb/tb_etapa_busqueda.sv | 122 ++++++++++++
 2 files changed

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage with IF/ID latch: drives the synchronous ROM, keeps a
// one-word skid so stalls never drop the in-flight fetch, and handles MEM redirects.
module etapa_busqueda #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [31:0] next_pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {ARRANQUE, CORRE, DETENIDO} estado_t;

  estado_t     state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        req_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_valid;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  assign imem_addr = branch_taken ? branch_target : fetch_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARRANQUE;
      fetch_pc    <= RESET_PC;
      req_valid   <= 1'b0;
      skid_valid  <= 1'b0;
      instr_out   <= NOP_WORD;
      next_pc_out <= 32'h0;
      valid_out   <= 1'b0;
    end else if (branch_taken) begin
      // Redirect: squash whatever was fetched and restart at the target.
      instr_out   <= NOP_WORD;
      next_pc_out <= 32'h0;
      valid_out   <= 1'b0;
      skid_valid  <= 1'b0;
      req_pc      <= branch_target;
      req_valid   <= 1'b1;
      fetch_pc    <= pc_inc(branch_target);
      state       <= CORRE;
    end else begin
      case (state)
        ARRANQUE: begin
          req_pc    <= fetch_pc;
          req_valid <= 1'b1;
          fetch_pc  <= pc_inc(fetch_pc);
          state     <= CORRE;
        end
        CORRE, DETENIDO: begin
          if (stall_in) begin
            // Only the first stalled edge sees a live ROM word; park it in the skid.
            if (state == CORRE) begin
              req_valid <= 1'b0;
              if (req_valid && !skid_valid) begin
                skid_instr <= imem_data;
                skid_pc    <= req_pc;
                skid_valid <= 1'b1;
              end
              state <= DETENIDO;
            end
          end else begin
            if (skid_valid) begin
              instr_out   <= skid_instr;
              next_pc_out <= pc_inc(skid_pc);
              valid_out   <= 1'b1;
            end else if (req_valid) begin
              instr_out   <= imem_data;
              next_pc_out <= pc_inc(req_pc);
              valid_out   <= 1'b1;
            end else begin
              instr_out   <= NOP_WORD;
              next_pc_out <= 32'h0;
              valid_out   <= 1'b0;
            end
            skid_valid <= 1'b0;
            req_pc     <= imem_addr;
            req_valid  <= 1'b1;
            fetch_pc   <= pc_inc(imem_addr);
            state      <= CORRE;
          end
        end
        default: state <= ARRANQUE;
      endcase
    end
  end

endmodule

// File: tb/tb_etapa_busqueda.sv
// Bench for etapa_busqueda: ROM returns 0x1000_0000+addr; outputs are predicted
// from the instruction-stream view of the stage (next address to emit per edge).
module tb_etapa_busqueda;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] ROM_BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_out;
  logic [31:0] next_pc_out;
  logic        valid_out;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state
  logic [31:0] pend;
  logic        startup;
  logic        exp_vld;
  logic [31:0] exp_instr;
  logic [31:0] exp_npc;
  logic        npc_known;

  always #5 clk = ~clk;

  always_ff @(posedge clk) imem_data <= ROM_BASE + imem_addr;

  etapa_busqueda #(.RESET_PC(RESET_PC), .PC_STEP(32'd4), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_out(instr_out), .next_pc_out(next_pc_out), .valid_out(valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      exp_vld = 1'b0; exp_instr = NOP_WORD; exp_npc = 32'h0; npc_known = 1'b1;
      pend = RESET_PC; startup = 1'b1;
    end else if (branch_taken) begin
      exp_vld = 1'b0; exp_instr = NOP_WORD; npc_known = 1'b0;
      pend = branch_target; startup = 1'b0;
    end else if (startup) begin
      startup = 1'b0;
    end else if (!stall_in) begin
      exp_vld = 1'b1; exp_instr = ROM_BASE + pend; exp_npc = pend + 32'd4;
      npc_known = 1'b1; pend = pend + 32'd4;
    end
    #1;
    chk("valid", {31'b0, valid_out}, {31'b0, exp_vld});
    chk("instr", instr_out, exp_instr);
    if (npc_known) chk("next_pc", next_pc_out, exp_npc);
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; stall_in = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tick(); chk("first_instr", instr_out, 32'h1000_0000);
    chk("first_npc", next_pc_out, 32'h4);
    tick(); tick(); chk("pre_stall", instr_out, 32'h1000_0008);
    stall_in = 1'b1;
    tick(); tick(); tick(); chk("stall_hold", instr_out, 32'h1000_0008);
    stall_in = 1'b0;
    tick(); chk("skid_word", instr_out, 32'h1000_000C);
    tick(); chk("after_skid", instr_out, 32'h1000_0010);
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    tick(); chk("br_bubble", {31'b0, valid_out}, 32'h0);
    branch_taken = 1'b0;
    tick(); chk("br_target", instr_out, 32'h1000_0100);
    chk("br_npc", next_pc_out, 32'h104);
    tick();
    stall_in = 1'b1;
    tick(); tick();
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    tick();
    branch_taken = 1'b0; stall_in = 1'b0;
    tick(); chk("br_stall_target", instr_out, 32'h1000_0100);
    tick();
    stall_in = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; stall_in = 1'b0;
    tick();
    tick(); chk("restart", instr_out, 32'h1000_0000);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick(); chk("wrap_instr", instr_out, 32'h0FFF_FFFC);
    chk("wrap_npc", next_pc_out, 32'h0);
    tick(); chk("wrap_next", instr_out, 32'h1000_0000);
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(0, 49) != 0);
      stall_in     = ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 9) == 0);
      r = $urandom;
      branch_target = {r[31:2], 2'b00};
      tick();
      if (!valid_out) chk("bubble_nop", instr_out, NOP_WORD);
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
